// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar: arbiter FSM states, command encoding,
// the timeout error pattern and default bus widths shared with masters/slaves.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/xbar_arbiter_2to1_if.sv
// Bus bundle around the 2:1 arbiter: both master ports and the slave port.
// modport master: the surrounding world (masters issuing requests, slave answering).
// modport slave : the arbiter itself, serving the masters and driving the slave.
interface xbar_arbiter_2to1_if
  import xbar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              m0_req;
  logic              m0_cmd;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_cmd;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic              s_req;
  logic              s_cmd;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_ack;
  logic [DATA_W-1:0] s_rdata;

  modport master (
    output m0_req, m0_cmd, m0_addr, m0_wdata,
    output m1_req, m1_cmd, m1_addr, m1_wdata,
    output s_ack, s_rdata,
    input  m0_ack, m0_rdata, m0_err,
    input  m1_ack, m1_rdata, m1_err,
    input  s_req, s_cmd, s_addr, s_wdata
  );

  modport slave (
    input  m0_req, m0_cmd, m0_addr, m0_wdata,
    input  m1_req, m1_cmd, m1_addr, m1_wdata,
    input  s_ack, s_rdata,
    output m0_ack, m0_rdata, m0_err,
    output m1_ack, m1_rdata, m1_err,
    output s_req, s_cmd, s_addr, s_wdata
  );

endinterface

// File: rtl/xbar_arbiter_2to1_rr_arb2.sv
// Combinational two-way round-robin pick. The pointer register lives in the parent.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_winner
);

  // On contention the master that did not win last time gets the grant.
  always_comb begin
    o_valid  = |i_req;
    o_winner = (&i_req) ? ~i_last : i_req[1];
  end

endmodule

// File: rtl/xbar_arbiter_2to1.sv
// Two-master, one-slave round-robin arbiter, one transaction in flight at a time.
// Optional request timeout enabled by defining XBAR_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | sampling master requests, slave port idle
// REQ   | s_req held with frozen s_* fields, waiting for s_ack
// RESP  | one-cycle ack pulse to the granted master, requests not sampled
module xbar_arbiter_2to1
  import xbar_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  xbar_arbiter_2to1_if.slave bus
);

  state_t            r_state,    w_state_nxt;
  logic              r_last,     w_last_nxt;
  logic              r_owner,    w_owner_nxt;
  logic              r_s_req,    w_s_req_nxt;
  logic              r_s_cmd,    w_s_cmd_nxt;
  logic [ADDR_W-1:0] r_s_addr,   w_s_addr_nxt;
  logic [DATA_W-1:0] r_s_wdata,  w_s_wdata_nxt;
  logic              r_m0_ack,   w_m0_ack_nxt;
  logic              r_m1_ack,   w_m1_ack_nxt;
  logic [DATA_W-1:0] r_m0_rdata, w_m0_rdata_nxt;
  logic [DATA_W-1:0] r_m1_rdata, w_m1_rdata_nxt;

  logic              w_gnt_valid;
  logic              w_gnt_winner;

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic              r_m0_err,   w_m0_err_nxt;
  logic              r_m1_err,   w_m1_err_nxt;
  logic [7:0]        r_cnt,      w_cnt_nxt;
`endif

  rr_arb2 u_rr_arb2 (
    .i_req    ({bus.m1_req, bus.m0_req}),
    .i_last   (r_last),
    .o_valid  (w_gnt_valid),
    .o_winner (w_gnt_winner)
  );

  // Register the state and every output; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_s_req    <= 1'b0;
      r_s_cmd    <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
`ifdef XBAR_ARB_TIMEOUT_EN
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_owner    <= w_owner_nxt;
      r_s_req    <= w_s_req_nxt;
      r_s_cmd    <= w_s_cmd_nxt;
      r_s_addr   <= w_s_addr_nxt;
      r_s_wdata  <= w_s_wdata_nxt;
      r_m0_ack   <= w_m0_ack_nxt;
      r_m1_ack   <= w_m1_ack_nxt;
      r_m0_rdata <= w_m0_rdata_nxt;
      r_m1_rdata <= w_m1_rdata_nxt;
`ifdef XBAR_ARB_TIMEOUT_EN
      r_m0_err   <= w_m0_err_nxt;
      r_m1_err   <= w_m1_err_nxt;
      r_cnt      <= w_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output decode; acks/errs are single-cycle pulses.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_owner_nxt    = r_owner;
    w_s_req_nxt    = r_s_req;
    w_s_cmd_nxt    = r_s_cmd;
    w_s_addr_nxt   = r_s_addr;
    w_s_wdata_nxt  = r_s_wdata;
    w_m0_ack_nxt   = 1'b0;
    w_m1_ack_nxt   = 1'b0;
    w_m0_rdata_nxt = r_m0_rdata;
    w_m1_rdata_nxt = r_m1_rdata;
`ifdef XBAR_ARB_TIMEOUT_EN
    w_m0_err_nxt   = 1'b0;
    w_m1_err_nxt   = 1'b0;
    w_cnt_nxt      = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt   = REQ;
          w_owner_nxt   = w_gnt_winner;
          w_last_nxt    = w_gnt_winner;
          w_s_req_nxt   = 1'b1;
          w_s_cmd_nxt   = w_gnt_winner ? bus.m1_cmd   : bus.m0_cmd;
          w_s_addr_nxt  = w_gnt_winner ? bus.m1_addr  : bus.m0_addr;
          w_s_wdata_nxt = w_gnt_winner ? bus.m1_wdata : bus.m0_wdata;
`ifdef XBAR_ARB_TIMEOUT_EN
          w_cnt_nxt     = '0;
`endif
        end
      end
      REQ: begin
        if (bus.s_ack) begin
          w_state_nxt = RESP;
          w_s_req_nxt = 1'b0;
          if (r_owner) begin
            w_m1_ack_nxt   = 1'b1;
            w_m1_rdata_nxt = bus.s_rdata;
          end else begin
            w_m0_ack_nxt   = 1'b1;
            w_m0_rdata_nxt = bus.s_rdata;
          end
        end
`ifdef XBAR_ARB_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_state_nxt = RESP;
          w_s_req_nxt = 1'b0;
          if (r_owner) begin
            w_m1_ack_nxt   = 1'b1;
            w_m1_err_nxt   = 1'b1;
            w_m1_rdata_nxt = DATA_W'(ERR_PATTERN);
          end else begin
            w_m0_ack_nxt   = 1'b1;
            w_m0_err_nxt   = 1'b1;
            w_m0_rdata_nxt = DATA_W'(ERR_PATTERN);
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.s_req    = r_s_req;
  assign bus.s_cmd    = r_s_cmd;
  assign bus.s_addr   = r_s_addr;
  assign bus.s_wdata  = r_s_wdata;
  assign bus.m0_ack   = r_m0_ack;
  assign bus.m1_ack   = r_m1_ack;
  assign bus.m0_rdata = r_m0_rdata;
  assign bus.m1_rdata = r_m1_rdata;
`ifdef XBAR_ARB_TIMEOUT_EN
  assign bus.m0_err   = r_m0_err;
  assign bus.m1_err   = r_m1_err;
`else
  assign bus.m0_err   = 1'b0;
  assign bus.m1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_arbiter_2to1.sv
// Bench for xbar_arbiter_2to1: vector table, directed corner sequences and a
// randomized run against a cycle-count transaction model.
module tb_xbar_arbiter_2to1;
  import xbar_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;
`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int STAB_CYC = TO - 1;
`else
  localparam int STAB_CYC = 10;
`endif
  localparam int RND_CYC = 600;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  xbar_arbiter_2to1_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  xbar_arbiter_2to1 #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.m0_req = 0; bus.m0_cmd = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_cmd = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.s_ack = 0; bus.s_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".s_req"},    bus.s_req, 0);
    chk({tag, ".s_cmd"},    bus.s_cmd, 0);
    chk({tag, ".s_addr"},   bus.s_addr, 0);
    chk({tag, ".s_wdata"},  bus.s_wdata, 0);
    chk({tag, ".m0_ack"},   bus.m0_ack, 0);
    chk({tag, ".m1_ack"},   bus.m1_ack, 0);
    chk({tag, ".m0_rdata"}, bus.m0_rdata, 0);
    chk({tag, ".m1_rdata"}, bus.m1_rdata, 0);
    chk({tag, ".m0_err"},   bus.m0_err, 0);
    chk({tag, ".m1_err"},   bus.m1_err, 0);
  endtask

  // Row: inputs driven in one cycle, expected outputs in the following cycle.
  typedef struct {
    logic        req0, req1, cmd0, cmd1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic        sack;
    logic [31:0] srd;
    logic        e_sreq, e_ack0, e_ack1, chk_s, e_cmd;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(
    logic req0, logic req1, logic cmd0, logic cmd1,
    logic [31:0] addr0, logic [31:0] addr1, logic [31:0] wd0, logic [31:0] wd1,
    logic sack, logic [31:0] srd,
    logic e_sreq, logic e_ack0, logic e_ack1, logic chk_s, logic e_cmd,
    logic [31:0] e_addr, logic [31:0] e_wd, logic [31:0] e_rd0, logic [31:0] e_rd1);
    vec_t v;
    v.req0 = req0; v.req1 = req1; v.cmd0 = cmd0; v.cmd1 = cmd1;
    v.addr0 = addr0; v.addr1 = addr1; v.wd0 = wd0; v.wd1 = wd1;
    v.sack = sack; v.srd = srd;
    v.e_sreq = e_sreq; v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.chk_s = chk_s; v.e_cmd = e_cmd;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    return v;
  endfunction

  // Transaction model state for the random run.
  bit          m_busy;
  bit          m_last;
  int          m_owner, m_gnt_c, m_ack_c, m_ack_own, m_sample_from;
  bit          m_err;
  logic        m_cmd;
  logic [31:0] m_addr, m_wd;
  logic [31:0] m_rd [2];
  bit          hold [2];
  logic        mcmd [2];
  logic [31:0] maddr [2], mwd [2];

  initial begin
    logic [31:0] A0, A1, W0, W1, R1, R2, R3, RD;
    int c;
    bit active, sack;
    logic [31:0] srd;
    int w;

    A0 = 32'h0000_0100; A1 = 32'h0000_0104;
    W0 = 32'hA0A0_0001; W1 = 32'hB1B1_0002;
    R1 = 32'h1111_0001; R2 = 32'h2222_0002; R3 = 32'h3333_0003;
    RD = 32'h1234_5678;

    // Contention with both masters writing continuously: grants 0,1,0.
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,0,0,  1,0,0,1,1,A0,W0,0,0));
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,1,R1, 0,1,0,0,0,0,0,R1,0));
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,0,0,  0,0,0,0,0,0,0,R1,0));
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,0,0,  1,0,0,1,1,A1,W1,R1,0));
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,1,R2, 0,0,1,0,0,0,0,R1,R2));
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,0,0,  0,0,0,0,0,0,0,R1,R2));
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,0,0,  1,0,0,1,1,A0,W0,R1,R2));
    vecs.push_back(mkv(1,1,1,1,A0,A1,W0,W1,1,R3, 0,1,0,0,0,0,0,R3,R2));
    vecs.push_back(mkv(0,0,0,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,R3,R2));
    // Single read by m0 at 0x10, slave acks in the second REQ cycle.
    vecs.push_back(mkv(1,0,0,0,32'h10,0,0,0,0,0,  1,0,0,1,0,32'h10,0,R3,R2));
    vecs.push_back(mkv(1,0,0,0,32'h10,0,0,0,0,0,  1,0,0,1,0,32'h10,0,R3,R2));
    vecs.push_back(mkv(1,0,0,0,32'h10,0,0,0,1,RD, 0,1,0,0,0,0,0,RD,R2));
    vecs.push_back(mkv(0,0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,RD,R2));

    drive_idle();
    reset = 0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1;

    foreach (vecs[i]) begin
      bus.m0_req = vecs[i].req0; bus.m0_cmd = vecs[i].cmd0;
      bus.m0_addr = vecs[i].addr0; bus.m0_wdata = vecs[i].wd0;
      bus.m1_req = vecs[i].req1; bus.m1_cmd = vecs[i].cmd1;
      bus.m1_addr = vecs[i].addr1; bus.m1_wdata = vecs[i].wd1;
      bus.s_ack = vecs[i].sack; bus.s_rdata = vecs[i].srd;
      tick();
      chk($sformatf("vec%0d.s_req", i),    bus.s_req,    vecs[i].e_sreq);
      chk($sformatf("vec%0d.m0_ack", i),   bus.m0_ack,   vecs[i].e_ack0);
      chk($sformatf("vec%0d.m1_ack", i),   bus.m1_ack,   vecs[i].e_ack1);
      chk($sformatf("vec%0d.m0_rdata", i), bus.m0_rdata, vecs[i].e_rd0);
      chk($sformatf("vec%0d.m1_rdata", i), bus.m1_rdata, vecs[i].e_rd1);
      chk($sformatf("vec%0d.m0_err", i),   bus.m0_err,   0);
      chk($sformatf("vec%0d.m1_err", i),   bus.m1_err,   0);
      if (vecs[i].chk_s) begin
        chk($sformatf("vec%0d.s_cmd", i),   bus.s_cmd,   vecs[i].e_cmd);
        chk($sformatf("vec%0d.s_addr", i),  bus.s_addr,  vecs[i].e_addr);
        chk($sformatf("vec%0d.s_wdata", i), bus.s_wdata, vecs[i].e_wd);
      end
    end

    // Stability: m1 scribbles on its fields while the slave stalls.
    drive_idle();
    bus.m1_req = 1; bus.m1_cmd = CMD_READ; bus.m1_addr = 32'h200; bus.m1_wdata = 32'h55;
    tick();
    chk("stab.s_req0", bus.s_req, 1);
    for (int k = 0; k < STAB_CYC; k++) begin
      bus.m1_addr = $urandom; bus.m1_cmd = ~bus.m1_cmd; bus.m1_wdata = $urandom;
      tick();
      chk("stab.s_req", bus.s_req, 1);
      chk("stab.s_addr", bus.s_addr, 32'h200);
      chk("stab.s_cmd", bus.s_cmd, CMD_READ);
      chk("stab.s_wdata", bus.s_wdata, 32'h55);
      chk("stab.m1_ack", bus.m1_ack, 0);
    end
    bus.s_ack = 1; bus.s_rdata = 32'hCAFE_0001;
    tick();
    chk("stab.m1_ack_done", bus.m1_ack, 1);
    chk("stab.m1_err", bus.m1_err, 0);
    chk("stab.m1_rdata", bus.m1_rdata, 32'hCAFE_0001);
    chk("stab.m0_ack", bus.m0_ack, 0);
    drive_idle();
    tick();
    chk("stab.idle_ack", bus.m1_ack, 0);

    // Reset mid-REQ with m0 owning the slave, then contention must go to m0.
    bus.m0_req = 1; bus.m0_cmd = CMD_WRITE; bus.m0_addr = A0; bus.m0_wdata = W0;
    tick();
    chk("rst.s_req_pre", bus.s_req, 1);
    reset = 0;
    bus.s_ack = 1; bus.s_rdata = 32'hBAD0_BAD0;
    tick();
    chk_all_zero("rst");
    reset = 1;
    bus.s_ack = 0;
    bus.m1_req = 1; bus.m1_cmd = CMD_WRITE; bus.m1_addr = A1; bus.m1_wdata = W1;
    tick();
    chk("rst.s_req_post", bus.s_req, 1);
    chk("rst.s_wdata_post", bus.s_wdata, W0);
    chk("rst.m0_ack_post", bus.m0_ack, 0);
    chk("rst.m1_ack_post", bus.m1_ack, 0);
    bus.s_ack = 1; bus.s_rdata = R1;
    tick();
    chk("rst.m0_ack_done", bus.m0_ack, 1);
    chk("rst.m1_ack_done", bus.m1_ack, 0);
    drive_idle();
    tick();

    // Slave never answers.
    bus.m0_req = 1; bus.m0_cmd = CMD_READ; bus.m0_addr = 32'h400;
    tick();
    chk("to.s_req1", bus.s_req, 1);
`ifdef XBAR_ARB_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      chk("to.s_req", bus.s_req, 1);
      chk("to.m0_ack_early", bus.m0_ack, 0);
    end
    tick();
    chk("to.s_req_drop", bus.s_req, 0);
    chk("to.m0_ack", bus.m0_ack, 1);
    chk("to.m0_err", bus.m0_err, 1);
    chk("to.m0_rdata", bus.m0_rdata, ERR_PATTERN);
    chk("to.m1_ack", bus.m1_ack, 0);
    drive_idle();
    tick();
    chk("to.m0_err_clr", bus.m0_err, 0);
    chk("to.m0_ack_clr", bus.m0_ack, 0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("to.s_req", bus.s_req, 1);
      chk("to.m0_ack", bus.m0_ack, 0);
      chk("to.m0_err", bus.m0_err, 0);
    end
    bus.s_ack = 1; bus.s_rdata = 32'h0BAD_F00D;
    tick();
    chk("to.m0_ack_late", bus.m0_ack, 1);
    chk("to.m0_err_late", bus.m0_err, 0);
    chk("to.m0_rdata_late", bus.m0_rdata, 32'h0BAD_F00D);
    drive_idle();
    tick();
`endif

    // Randomized run against the transaction model, starting from reset.
    reset = 0;
    tick();
    reset = 1;
    m_busy = 0; m_last = 1; m_owner = 0; m_gnt_c = -10; m_ack_c = -1; m_ack_own = 0;
    m_sample_from = 0; m_err = 0; m_cmd = 0; m_addr = '0; m_wd = '0;
    m_rd[0] = '0; m_rd[1] = '0;
    for (int i = 0; i < 2; i++) begin
      hold[i] = 0; mcmd[i] = 0; maddr[i] = '0; mwd[i] = '0;
    end
    c = 0;
    while ((c < RND_CYC || m_busy || hold[0] || hold[1]) && c < RND_CYC + 2000) begin
      active = (c < RND_CYC);
      chk("rnd.s_req", bus.s_req, m_busy);
      if (m_busy) begin
        chk("rnd.s_cmd", bus.s_cmd, m_cmd);
        chk("rnd.s_addr", bus.s_addr, m_addr);
        chk("rnd.s_wdata", bus.s_wdata, m_wd);
      end
      chk("rnd.m0_ack", bus.m0_ack, (m_ack_c == c && m_ack_own == 0));
      chk("rnd.m1_ack", bus.m1_ack, (m_ack_c == c && m_ack_own == 1));
      chk("rnd.m0_err", bus.m0_err, (m_ack_c == c && m_ack_own == 0 && m_err));
      chk("rnd.m1_err", bus.m1_err, (m_ack_c == c && m_ack_own == 1 && m_err));
      chk("rnd.m0_rdata", bus.m0_rdata, m_rd[0]);
      chk("rnd.m1_rdata", bus.m1_rdata, m_rd[1]);

      for (int i = 0; i < 2; i++) begin
        if (hold[i] && m_ack_c == c && m_ack_own == i) hold[i] = 0;
        if (!hold[i] && active && $urandom_range(0, 2) == 0) begin
          hold[i] = 1;
          mcmd[i] = 1'($urandom_range(0, 1));
          maddr[i] = $urandom;
          mwd[i] = $urandom;
        end else if (hold[i] && m_busy && m_owner == i && $urandom_range(0, 1) == 1) begin
          maddr[i] = $urandom;
          mwd[i] = $urandom;
          mcmd[i] = ~mcmd[i];
        end
      end
      sack = ($urandom_range(0, 2) == 0);
      srd = $urandom;
      bus.m0_req = hold[0]; bus.m0_cmd = mcmd[0]; bus.m0_addr = maddr[0]; bus.m0_wdata = mwd[0];
      bus.m1_req = hold[1]; bus.m1_cmd = mcmd[1]; bus.m1_addr = maddr[1]; bus.m1_wdata = mwd[1];
      bus.s_ack = sack; bus.s_rdata = srd;

      if (m_busy) begin
        if (sack) begin
          m_busy = 0; m_rd[m_owner] = srd; m_err = 0;
          m_ack_c = c + 1; m_ack_own = m_owner; m_sample_from = c + 2;
        end
`ifdef XBAR_ARB_TIMEOUT_EN
        else if (c - m_gnt_c == TO) begin
          m_busy = 0; m_rd[m_owner] = ERR_PATTERN; m_err = 1;
          m_ack_c = c + 1; m_ack_own = m_owner; m_sample_from = c + 2;
        end
`endif
      end else if (c >= m_sample_from && (hold[0] || hold[1])) begin
        if (hold[0] && hold[1]) w = m_last ? 0 : 1;
        else w = hold[1] ? 1 : 0;
        m_busy = 1; m_owner = w; m_gnt_c = c; m_last = (w == 1);
        m_cmd = mcmd[w]; m_addr = maddr[w]; m_wd = mwd[w];
      end
      tick();
      c++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
